// File: rtl/hex_display_scanner.sv
// hex_display_scanner: time-multiplexed 7-segment driver with a valid/ready load port.
// The displayed word changes only at frame boundaries, and every digit slot starts with a dark dead-time.
`default_nettype none

module hex_display_scanner #(
  parameter int NUM_DIGITS     = 4,
  parameter int ON_CYCLES      = 1000,
  parameter int BLANK_CYCLES   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [4*NUM_DIGITS-1:0]   load_value,
  input  logic [NUM_DIGITS-1:0]     load_dp,
  input  logic [NUM_DIGITS-1:0]     load_blank,
  output logic [0:6]                segments,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     digit_en,
  output logic                      frame_done
);

  localparam int MAX_CYCLES = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam int IW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  localparam logic [0:6]            SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_ACTIVE_LOW}};

  typedef enum logic [0:0] {
    S_BLANK = 1'b0,
    S_ON    = 1'b1
  } state_t;

  state_t                    state, state_nx;
  logic [CW-1:0]             cnt, cnt_nx;
  logic [IW-1:0]             idx, idx_nx;
  logic                      boundary;

  logic                      pending;
  logic [4*NUM_DIGITS-1:0]   pend_value;
  logic [NUM_DIGITS-1:0]     pend_dp;
  logic [NUM_DIGITS-1:0]     pend_blank;
  logic [4*NUM_DIGITS-1:0]   act_value;
  logic [NUM_DIGITS-1:0]     act_dp;
  logic [NUM_DIGITS-1:0]     act_blank;

  logic                      accept;
  logic                      copy;
  logic                      pending_nx;
  logic                      lit;
  logic [3:0]                nibble;
  logic [0:6]                seg_dec;
  logic [0:6]                seg_nx;
  logic                      dp_nx;
  logic [NUM_DIGITS-1:0]     dig_nx;

  hex_decoder u_dec (
    .value   (nibble),
    .display (seg_dec)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    idx_nx   = idx;
    boundary = 1'b0;
    case (state)
      S_BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_nx = S_ON;
          cnt_nx   = '0;
        end
      end
      S_ON: begin
        if (cnt == ON_LAST) begin
          state_nx = S_BLANK;
          cnt_nx   = '0;
          boundary = (idx == IDX_LAST);
          idx_nx   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
      end
      default: begin
        state_nx = S_BLANK;
        cnt_nx   = '0;
      end
    endcase
  end

  // Copy and accept are mutually exclusive: load_ready is low whenever a word is pending.
  always_comb begin
    accept     = load_valid && load_ready;
    copy       = boundary && pending;
    pending_nx = pending;
    if (accept) begin
      pending_nx = 1'b1;
    end else if (copy) begin
      pending_nx = 1'b0;
    end
  end

  // Outputs are computed for the post-edge state so they switch together with the FSM.
  always_comb begin
    lit    = (state_nx == S_ON) && !act_blank[idx_nx];
    nibble = act_value[{idx_nx, 2'b00} +: 4];
    seg_nx = '0;
    dp_nx  = 1'b0;
    dig_nx = '0;
    if (lit) begin
      seg_nx         = seg_dec;
      dp_nx          = act_dp[idx_nx];
      dig_nx[idx_nx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_BLANK;
      cnt        <= '0;
      idx        <= '0;
      pending    <= 1'b0;
      load_ready <= 1'b1;
      pend_value <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      act_value  <= '0;
      act_dp     <= '0;
      act_blank  <= '1;
      segments   <= SEG_OFF;
      dp         <= SEG_ACTIVE_LOW;
      digit_en   <= DIG_OFF;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      idx        <= idx_nx;
      pending    <= pending_nx;
      load_ready <= !pending_nx;
      if (accept) begin
        pend_value <= load_value;
        pend_dp    <= load_dp;
        pend_blank <= load_blank;
      end
      if (copy) begin
        act_value <= pend_value;
        act_dp    <= pend_dp;
        act_blank <= pend_blank;
      end
      segments   <= seg_nx ^ SEG_OFF;
      dp         <= dp_nx ^ SEG_ACTIVE_LOW;
      digit_en   <= dig_nx ^ DIG_OFF;
      frame_done <= boundary;
    end
  end

endmodule

// Active-high hex to 7-segment decoder; display[0:6] = segments a..g.
module hex_decoder (
  input  logic [3:0] value,
  output logic [0:6] display
);

  always_comb begin
    display = 7'b0000000;
    case (value)
      4'h0: display = 7'b1111110;
      4'h1: display = 7'b0110000;
      4'h2: display = 7'b1101101;
      4'h3: display = 7'b1111001;
      4'h4: display = 7'b0110011;
      4'h5: display = 7'b1011011;
      4'h6: display = 7'b1011111;
      4'h7: display = 7'b1110000;
      4'h8: display = 7'b1111111;
      4'h9: display = 7'b1111011;
      4'hA: display = 7'b1110111;
      4'hB: display = 7'b0011111;
      4'hC: display = 7'b1001110;
      4'hD: display = 7'b0111101;
      4'hE: display = 7'b1001111;
      4'hF: display = 7'b1000111;
      default: display = 7'b0000000;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_hex_display_scanner.sv
// tb_hex_display_scanner: scoreboard bench; a timing/word model pushes expected outputs per edge.
`default_nettype none

module tb_hex_display_scanner;

  localparam int ND    = 4;
  localparam int ON    = 8;
  localparam int BL    = 2;
  localparam int SLOT  = ON + BL;
  localparam int FRAME = ND * SLOT;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_value = '0;
  logic [3:0]  load_dp    = '0;
  logic [3:0]  load_blank = '0;
  logic [6:0]  segments;
  logic        dp;
  logic [3:0]  digit_en;
  logic        frame_done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hex_display_scanner #(
    .NUM_DIGITS     (ND),
    .ON_CYCLES      (ON),
    .BLANK_CYCLES   (BL),
    .SEG_ACTIVE_LOW (1'b1),
    .DIG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .load_dp    (load_dp),
    .load_blank (load_blank),
    .segments   (segments),
    .dp         (dp),
    .digit_en   (digit_en),
    .frame_done (frame_done)
  );

  typedef struct {
    logic [6:0] seg;
    logic [3:0] dig;
    logic       dp;
    logic       rdy;
    logic       fd;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  // Segment patterns written a..g from the MSB, active high.
  function automatic logic [6:0] seg_hi(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1111110;
      4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;
      4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;
      4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;
      4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;
      4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;
      4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;
      default: return 7'b1000111;
    endcase
  endfunction

  int          t;
  bit          m_pend;
  bit          m_ready;
  logic [15:0] m_pv, m_av;
  logic [3:0]  m_pdp, m_adp, m_pbl, m_abl;
  int          m_s, m_d;
  bit          m_lit;
  logic [3:0]  m_nib;
  exp_t        m_e;

  // Model: t counts edges since reset release; blank while t%SLOT < BL, digit = (t/SLOT)%ND.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        t = 0; m_pend = 0; m_ready = 1;
        m_pv = '0; m_pdp = '0; m_pbl = '0;
        m_av = '0; m_adp = '0; m_abl = '1;
        sb.delete();
      end else begin
        t++;
        if ((t % FRAME == 0) && m_pend) begin
          m_av = m_pv; m_adp = m_pdp; m_abl = m_pbl; m_pend = 0;
        end else if (load_valid && m_ready) begin
          m_pv = load_value; m_pdp = load_dp; m_pbl = load_blank; m_pend = 1;
        end
        m_ready = !m_pend;
        m_s   = t % SLOT;
        m_d   = (t / SLOT) % ND;
        m_lit = (m_s >= BL) && !m_abl[m_d];
        m_nib = m_av[4*m_d +: 4];
        m_e.seg = m_lit ? ~seg_hi(m_nib) : 7'h7F;
        m_e.dig = m_lit ? ~(4'b0001 << m_d) : 4'hF;
        m_e.dp  = m_lit ? ~m_adp[m_d] : 1'b1;
        m_e.rdy = m_ready;
        m_e.fd  = (t % FRAME == 0);
        sb.push_back(m_e);
      end
    end
  end

  exp_t mon_e;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", sb.size(), 1);
        end else begin
          mon_e = sb.pop_front();
          chk("segments",   segments,   mon_e.seg);
          chk("digit_en",   digit_en,   mon_e.dig);
          chk("dp",         dp,         mon_e.dp);
          chk("load_ready", load_ready, mon_e.rdy);
          chk("frame_done", frame_done, mon_e.fd);
        end
      end
    end
  end

  // All stimulus tasks start and end at negedge+1.
  task automatic load_word(input logic [15:0] v, input logic [3:0] dpv, input logic [3:0] blv);
    int n;
    load_value = v; load_dp = dpv; load_blank = blv; load_valid = 1'b1;
    n = 0;
    while (!load_ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    chk("load_accept_wait", load_ready, 1);
    @(posedge clk);
    @(negedge clk); #1;
    load_valid = 1'b0;
  endtask

  task automatic wait_dig(input logic [3:0] en);
    bit found;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk); #1;
      if (digit_en == en) found = 1;
    end
    chk("wait_digit", found, 1);
  endtask

  task automatic wait_fd();
    bit found;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk); #1;
      if (frame_done) found = 1;
    end
    chk("wait_frame_done", found, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  int c0, c1, c2, c3, cdark, cfd;

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_segments",   segments,   7'h7F);
    chk("rst_digit_en",   digit_en,   4'hF);
    chk("rst_dp",         dp,         1'b1);
    chk("rst_load_ready", load_ready, 1'b1);
    chk("rst_frame_done", frame_done, 1'b0);
    rst_n = 1'b1;

    // Idle: dark display, one frame_done at edge 40.
    repeat (45) begin @(negedge clk); #1; end

    // Single load and per-digit decode.
    load_word(16'h12AF, 4'b0000, 4'b0000);
    chk("ready_drop", load_ready, 1'b0);
    wait_dig(4'b1110); chk("digit0_F", segments, 7'b0111000);
    wait_dig(4'b1101); chk("digit1_A", segments, 7'b0001000);
    wait_dig(4'b1011); chk("digit2_2", segments, 7'b0010010);
    wait_dig(4'b0111); chk("digit3_1", segments, 7'b1001111);

    // Back-to-back loads: the second stalls until the first is copied.
    load_word(16'h3456, 4'b0000, 4'b0000);
    load_word(16'h0000, 4'b0000, 4'b0000);
    wait_dig(4'b1110); chk("second_frame_6", segments, 7'b0100000);
    wait_fd();
    wait_dig(4'b1110); chk("third_frame_0", segments, 7'b0000001);

    // Slot timing over exactly one frame.
    wait_fd();
    c0 = 0; c1 = 0; c2 = 0; c3 = 0; cdark = 0; cfd = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk); #1;
      case (digit_en)
        4'b1110: c0++;
        4'b1101: c1++;
        4'b1011: c2++;
        4'b0111: c3++;
        4'b1111: cdark++;
        default: ;
      endcase
      if (frame_done) cfd++;
    end
    chk("on_digit0", c0, ON);
    chk("on_digit1", c1, ON);
    chk("on_digit2", c2, ON);
    chk("on_digit3", c3, ON);
    chk("dark_clocks", cdark, ND * BL);
    chk("frame_done_count", cfd, 1);

    // Blanked digit 2 and decimal point on digit 0.
    load_word(16'h7B9C, 4'b0001, 4'b0100);
    wait_fd();
    wait_dig(4'b1110);
    chk("digit0_dp", dp, 1'b0);
    chk("digit0_C", segments, 7'b0110001);
    repeat (2 * FRAME) begin @(negedge clk); #1; end

    // Reset during digit 1 with a word pending.
    wait_fd();
    load_word(16'hBEEF, 4'b0000, 4'b0000);
    wait_dig(4'b1101);
    repeat (2) begin @(negedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("midrst_segments",   segments,   7'h7F);
    chk("midrst_digit_en",   digit_en,   4'hF);
    chk("midrst_dp",         dp,         1'b1);
    chk("midrst_load_ready", load_ready, 1'b1);
    chk("midrst_frame_done", frame_done, 1'b0);
    repeat (3) begin @(negedge clk); #1; end
    rst_n = 1'b1;
    repeat (90) begin @(negedge clk); #1; end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hex_display_scanner.md
Name: hex_display_scanner

Overview:
Time-multiplexed driver for a bank of common-enable 7-segment digits. It buffers a multi-digit hex word through a valid/ready load port and scans the digits one at a time. Each digit value goes through one hex_decoder instance. A dead-time slot between digits prevents ghosting, and the displayed word updates only at frame boundaries so no frame is ever torn.

Parameters:
NUM_DIGITS, 4, number of digits scanned; range 1..16
ON_CYCLES, 1000, clocks each digit is lit per slot; at least 1
BLANK_CYCLES, 16, dead-time clocks before each digit's on phase; at least 1
SEG_ACTIVE_LOW, 1, when 1, segments and dp are driven inverted
DIG_ACTIVE_LOW, 1, when 1, digit_en is driven inverted

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
load_valid  in  1  new display word offered
load_ready  out  1  scanner can accept a word
load_value  in  4*NUM_DIGITS  hex nibbles; digit i = load_value[4i+3:4i]
load_dp  in  NUM_DIGITS  decimal-point enable per digit
load_blank  in  NUM_DIGITS  per-digit blank; 1 = digit dark
segments  out  7  segments a..g as index 0..6, same order as hex_decoder display[0:6]
dp  out  1  decimal point
digit_en  out  NUM_DIGITS  one-hot digit enable
frame_done  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n), with synchronous deassertion handled upstream.
- Reset state (asserted asynchronously):
  - state = BLANK, digit index = 0, slot counter = 0.
  - pending buffer empty, so load_ready = 1.
  - active value = 0, active dp = 0, active blank = all 1s.
  - segments, dp and digit_en are at their inactive level: all 1s when the matching ACTIVE_LOW parameter is 1, otherwise all 0s.
  - frame_done = 0.
- Load handshake:
  - A transfer occurs on a clock edge where load_valid and load_ready are both 1.
  - The word is captured into the pending buffer and the pending flag is set.
  - load_ready is registered and equals the inverse of the pending flag, so it drops the cycle after the accept.
  - The pending buffer never changes while the pending flag is set. load_valid held high while load_ready is 0 stalls with no effect.
- FSM states:
  - BLANK: all digit_en inactive; segments and dp inactive. Lasts BLANK_CYCLES clocks, then goes to ON with the counter reset.
  - ON: digit_en[idx] active; segments = hex_decoder(active nibble idx); dp = active dp[idx]. Lasts ON_CYCLES clocks, then goes to BLANK and idx advances.
- Index wrap: idx advances modulo NUM_DIGITS; after NUM_DIGITS-1 it returns to 0.
- Blanked digit: if active blank[idx] = 1, the ON phase keeps digit_en, segments and dp inactive. The slot is still consumed, so frame timing is unchanged.
- Frame boundary: the last clock of the ON phase for idx = NUM_DIGITS-1.
  - At that edge, frame_done goes to 1 for exactly one cycle.
  - If the pending flag is set, the pending buffer copies into the active registers and the pending flag clears on the same edge.
  - load_ready rises on the cycle after the copy.
  - The new word is first visible in digit 0's ON phase of the next frame.
- Output timing:
  - All outputs are registered; no combinational path from inputs to outputs.
  - digit_en, segments and dp change together on the same edge as the state transition.
- Frame and slot lengths: frame = NUM_DIGITS*(BLANK_CYCLES+ON_CYCLES) clocks. The slot counter is wide enough for max(ON_CYCLES, BLANK_CYCLES).
- Simultaneous events:
  - An accept cannot coincide with a copy, because load_ready is 0 whenever the pending flag is set.
  - A load accepted on the frame-boundary edge itself waits for the next boundary.
- Reset mid-operation: all outputs go inactive immediately and the pending word is discarded. Scanning restarts at BLANK, idx 0.
- Polarity: decoding happens in active-high form; inversion is the final output stage only.

Test Plan:
Common configuration: NUM_DIGITS=4, ON_CYCLES=8, BLANK_CYCLES=2, SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=1 (slot = 10 clocks, frame = 40 clocks).
1. Reset, then idle for 40 clocks -> segments=7'b1111111, digit_en=4'b1111 throughout; load_ready=1; frame_done pulses once at clock 40.
2. Load 16'h12AF, dp=0, blank=0 -> load_ready low until the next frame_done. Next frame: digit0 segments=7'b0111000 ('F') with digit_en=4'b1110, digit1 segments=7'b0001000 ('A'), digit2=7'b0010010 ('2'), digit3=7'b1001111 ('1').
3. Hold load_valid high with 16'h0000 while a pending word exists -> no accept until load_ready returns high. The second word appears one frame after the first.
4. blank=4'b0100, dp=4'b0001 -> digit2 slot has digit_en=4'b1111 for all 10 clocks; digit0 ON phase has dp=0; frame length stays 40.
5. Assert rst_n low mid ON phase of digit 1 with a pending word -> outputs inactive in the same cycle. After release the display is dark and load_ready=1.
6. Check slot timing -> each digit_en is active exactly 8 consecutive clocks with 2 dark clocks between digits; the 3->0 wrap occurs, with one frame_done per frame.
